// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: state encodings and default widths.
package sum_accumulator_pkg;

    localparam int SUM_W_DEF     = 5;
    localparam int ACC_W_DEF     = 8;
    localparam int N_SAMPLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_sample_counter.sv
// Up-counter for accepted samples with synchronous clear and a terminal-count
// strobe that fires on the enabled cycle that takes the count to N_SAMPLES.
module sample_counter #(
    parameter int N_SAMPLES = 4,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
    assign tc    = en && (count_q == LAST);

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a burst of N_SAMPLES adder sums and hands the total downstream.
// Define SUM_ACC_SATURATE_EN to clamp the total on overflow instead of wrapping.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [SUM_W-1:0]                   sum_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [ACC_W-1:0]                   acc_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               overflow,
    output logic [1:0]                         dbg_state,
    output logic [$clog2(N_SAMPLES+1)-1:0]     dbg_count
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    // Handshake: a sample moves when in_valid && in_ready on a rising edge; a
    // result is consumed when out_valid && out_ready on a rising edge. Ready and
    // valid are decoded from state only, so neither depends on the other side.

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic              xfer;
    logic              launch;
    logic              last_xfer;
    logic [ACC_W:0]    sum_ext;
    logic              carry;
    logic [CNT_W-1:0]  count;

    assign launch = (state_q == ST_IDLE) && start;
    assign xfer   = in_valid && in_ready;

    sample_counter #(
        .N_SAMPLES (N_SAMPLES),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (xfer),
        .count (count),
        .tc    (last_xfer)
    );

    // One extra bit on the add so the carry out of the accumulator is visible.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_in};
    assign carry   = sum_ext[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_xfer) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (launch) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            if (carry) ovf_q <= 1'b1;
`ifdef SUM_ACC_SATURATE_EN
            // Once clamped the total stays pinned for the rest of the burst.
            if (carry || ovf_q) acc_q <= {ACC_W{1'b1}};
            else                acc_q <= sum_ext[ACC_W-1:0];
`else
            acc_q <= sum_ext[ACC_W-1:0];
`endif
        end
    end

    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;
    assign dbg_count = count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default-width instance plus an ACC_W=6
// instance driven in lockstep for the overflow case.
module tb_sum_accumulator;

    localparam int SUM_W = 5;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [SUM_W-1:0] sum_in;
    logic             in_valid;
    logic             out_ready;

    logic             in_ready, out_valid, busy, overflow;
    logic [7:0]       acc_out;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] dbg_count;

    logic             in_ready6, out_valid6, busy6, overflow6;
    logic [5:0]       acc_out6;
    logic [1:0]       dbg_state6;
    logic [CNT_W-1:0] dbg_count6;

    int total = 0;
    int bad   = 0;

    sum_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    sum_accumulator #(.ACC_W(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .acc_out   (acc_out6),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .busy      (busy6),
        .overflow  (overflow6),
        .dbg_state (dbg_state6),
        .dbg_count (dbg_count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [SUM_W-1:0] v);
        in_valid = 1'b1;
        sum_in   = v;
        @(negedge clk);
        in_valid = 1'b0;
        sum_in   = '0;
    endtask

    task automatic gap(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk(tag, in_ready, 1);
        end
    endtask

    task automatic release_result(input logic [7:0] exp_acc, input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, out_valid, 0);
        chk({tag, "_busy_drop"}, busy, 0);
        chk({tag, "_idle_acc"}, acc_out, exp_acc);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        sum_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_acc", acc_out, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", dbg_count, 0);
        rst_n = 1'b1;

        // Idle with no start: nothing happens.
        @(negedge clk);
        chk("idle_stays", dbg_state, 0);

        // Burst 5,11,15,23 then backpressure for 3 cycles.
        do_start();
        chk("b1_in_ready", in_ready, 1);
        chk("b1_busy", busy, 1);
        send(5'd5);
        send(5'd11);
        send(5'd15);
        chk("b1_not_done", out_valid, 0);
        send(5'd23);
        chk("b1_out_valid", out_valid, 1);
        chk("b1_acc", acc_out, 54);
        chk("b1_ovf", overflow, 0);
        chk("b1_in_ready_done", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_acc", acc_out, 54);
        end
        release_result(8'd54, "bp");

        // Same sums with two stall cycles between each.
        do_start();
        send(5'd5);
        gap(2, "gap_ready");
        send(5'd11);
        gap(2, "gap_ready");
        send(5'd15);
        gap(2, "gap_ready");
        chk("gap_partial_acc", acc_out, 31);
        chk("gap_count", dbg_count, 3);
        send(5'd23);
        chk("gap_out_valid", out_valid, 1);
        chk("gap_acc", acc_out, 54);
        release_result(8'd54, "gap");

        // Overflow: 4 x 31 = 124; wraps to 60 in a 6-bit accumulator.
        do_start();
        send(5'd31);
        send(5'd31);
        send(5'd31);
        send(5'd31);
        chk("ovf8_acc", acc_out, 124);
        chk("ovf8_flag", overflow, 0);
        chk("ovf6_valid", out_valid6, 1);
`ifdef SUM_ACC_SATURATE_EN
        chk("ovf6_acc", acc_out6, 63);
`else
        chk("ovf6_acc", acc_out6, 60);
`endif
        chk("ovf6_flag", overflow6, 1);
        release_result(8'd124, "ovf");
        chk("ovf6_flag_idle", overflow6, 1);

        // start during ACCUM and during DONE must be ignored.
        do_start();
        chk("ovf6_flag_cleared", overflow6, 0);
        send(5'd1);
        send(5'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_state", dbg_state, 1);
        chk("ign_count", dbg_count, 2);
        chk("ign_acc", acc_out, 3);
        send(5'd3);
        send(5'd4);
        chk("ign_acc_done", acc_out, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done_state", dbg_state, 2);
        chk("ign_done_acc", acc_out, 10);

        // Result handshake and a start in the very first IDLE cycle.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("first_idle_state", dbg_state, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_idle_start", dbg_state, 1);
        chk("first_idle_cleared", acc_out, 0);

        // Async reset mid-cycle, then a fresh burst.
        send(5'd1);
        send(5'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acc", acc_out, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_output", out_valid, 0);
        do_start();
        send(5'd1);
        send(5'd1);
        send(5'd1);
        send(5'd1);
        chk("arst_out_valid_new", out_valid, 1);
        chk("arst_acc_new", acc_out, 4);
        release_result(8'd4, "arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
